// File: rtl/uart_tx_feeder.sv
// Byte FIFO and frame pacer feeding a UART transmitter that has no busy output.
// Each byte stays on tx_data for a whole frame; starts are spaced FRAME_CLKS apart.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | transmitter free; pop head and pulse tx_start when FIFO non-empty
// SEND  | frame in flight; frame timer runs until the inter-frame gap ends
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 5626,
    parameter int GAP_CLKS     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy
);

    localparam int FRAME_CLKS = 10 * CLKS_PER_BIT + GAP_CLKS;
    localparam int TW         = $clog2(FRAME_CLKS);
    localparam int PW         = $clog2(DEPTH);
    localparam int LW         = $clog2(DEPTH + 1);

    localparam logic [TW-1:0] TIMER_END = TW'(FRAME_CLKS - 2);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop;
    logic            load;
    logic            push;
    logic            ovf_set;

    // A pop frees a slot in the same cycle, so a write into a full FIFO still lands then.
    assign push    = wr_en && (!full || pop);
    assign ovf_set = wr_en && full && !pop;
    assign full    = (level == LEVEL_MAX);
    assign busy    = (state == SEND) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Starting in SEND holds off the first start for a full frame: the
    // transmitter is not reset and may still be shifting out an old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEND;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (timer == TIMER_END) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = SEND;
        endcase
    end

    always_comb begin
        pop  = 1'b0;
        load = 1'b0;
        if (state == IDLE && level != '0) begin
            pop  = 1'b1;
            load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= load;
            if (load) begin
                timer   <= '0;
                tx_data <= mem[rd_ptr];
            end else if (state == SEND) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule
